// File: rtl/rsa_job_arbiter_if.sv
// Client/engine bus of rsa_job_arbiter: two requesters, tagged result and the modexp engine handshake.
// slave = arbiter view, master = environment (clients + engine) view.
interface rsa_job_arbiter_if #(
    parameter int W = 128
);
    logic         req0;
    logic         req1;
    logic [W-1:0] msg0;
    logic [W-1:0] key0;
    logic [W-1:0] n0;
    logic [W-1:0] msg1;
    logic [W-1:0] key1;
    logic [W-1:0] n1;
    logic         gnt0;
    logic         gnt1;
    logic [W-1:0] res;
    logic         res_valid;
    logic         res_id;
    logic         res_err;
    logic         busy;
    logic         eng_start;
    logic [W-1:0] eng_msg;
    logic [W-1:0] eng_key;
    logic [W-1:0] eng_n;
    logic [W-1:0] eng_c;
    logic         eng_done;
    logic         eng_abort;

    modport slave (
        input  req0, req1, msg0, key0, n0, msg1, key1, n1, eng_c, eng_done,
        output gnt0, gnt1, res, res_valid, res_id, res_err, busy,
               eng_start, eng_msg, eng_key, eng_n, eng_abort
    );

    modport master (
        output req0, req1, msg0, key0, n0, msg1, key1, n1, eng_c, eng_done,
        input  gnt0, gnt1, res, res_valid, res_id, res_err, busy,
               eng_start, eng_msg, eng_key, eng_n, eng_abort
    );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin arbiter sharing one modexp engine between encrypt (0) and decrypt (1) clients.
// Optional WAIT timeout with engine abort is enabled by defining RSA_ARB_TIMEOUT_EN.
module rsa_job_arbiter #(
    parameter int          W              = 128,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    rsa_job_arbiter_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        ERR
    } state_t;

    state_t       state;
    logic         sel_id;
    logic         last_id;

    logic         req0_eff;
    logic         req1_eff;
    logic         pick;
    logic [W-1:0] sel_msg;
    logic [W-1:0] sel_key;
    logic [W-1:0] sel_n;
    logic         op_bad;

`ifdef RSA_ARB_TIMEOUT_EN
    logic [31:0]  wait_cnt;
    logic         timed_out;
`endif

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // A request whose gnt is showing this cycle is already consumed (ERR path grants in IDLE).
    always_comb begin
        req0_eff = bus.req0 & ~bus.gnt0;
        req1_eff = bus.req1 & ~bus.gnt1;
        pick     = (req0_eff & req1_eff) ? ~last_id : req1_eff;
        sel_msg  = pick ? bus.msg1 : bus.msg0;
        sel_key  = pick ? bus.key1 : bus.key0;
        sel_n    = pick ? bus.n1   : bus.n0;
        op_bad   = (sel_n[W-1:1] == '0) || (sel_msg >= sel_n);
    end

    // Each state's actions are registered on the edge that leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            sel_id        <= 1'b0;
            last_id       <= 1'b1;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.res       <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.eng_start <= 1'b0;
            bus.eng_msg   <= '0;
            bus.eng_key   <= '0;
            bus.eng_n     <= '0;
`ifdef RSA_ARB_TIMEOUT_EN
            bus.eng_abort <= 1'b0;
            wait_cnt      <= '0;
            timed_out     <= 1'b0;
`endif
        end else begin
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.eng_start <= 1'b0;
`ifdef RSA_ARB_TIMEOUT_EN
            bus.eng_abort <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req0_eff || req1_eff) begin
                        bus.eng_msg <= sel_msg;
                        bus.eng_key <= sel_key;
                        bus.eng_n   <= sel_n;
                        sel_id      <= pick;
                        bus.busy    <= 1'b1;
                        state       <= op_bad ? ERR : ISSUE;
                    end
                end
                ISSUE: begin
                    bus.gnt0      <= ~sel_id;
                    bus.gnt1      <= sel_id;
                    bus.eng_start <= 1'b1;
                    last_id       <= sel_id;
`ifdef RSA_ARB_TIMEOUT_EN
                    wait_cnt      <= '0;
                    timed_out     <= 1'b0;
`endif
                    state         <= WAIT;
                end
                WAIT: begin
                    if (bus.eng_done) begin
                        bus.res <= bus.eng_c;
                        state   <= RESP;
                    end
`ifdef RSA_ARB_TIMEOUT_EN
                    else if (wait_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        bus.eng_abort <= 1'b1;
                        bus.res       <= '0;
                        timed_out     <= 1'b1;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
`endif
                end
                RESP: begin
                    bus.res_valid <= 1'b1;
                    bus.res_id    <= sel_id;
`ifdef RSA_ARB_TIMEOUT_EN
                    bus.res_err   <= timed_out;
`else
                    bus.res_err   <= 1'b0;
`endif
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                ERR: begin
                    bus.gnt0      <= ~sel_id;
                    bus.gnt1      <= sel_id;
                    bus.res_valid <= 1'b1;
                    bus.res       <= '0;
                    bus.res_err   <= 1'b1;
                    bus.res_id    <= sel_id;
                    last_id       <= sel_id;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifndef RSA_ARB_TIMEOUT_EN
    assign bus.eng_abort = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: vector table, corner sequences and a randomized round-robin model.
// Define RSA_ARB_TIMEOUT_EN to also exercise the engine timeout path (TIMEOUT_CYCLES=16).
module tb_rsa_job_arbiter;
    localparam int W = 128;
`ifdef RSA_ARB_TIMEOUT_EN
    localparam int unsigned TO = 16;
`else
    localparam int unsigned TO = 4096;
`endif

    typedef logic [W-1:0] word_t;
    typedef struct { word_t msg; word_t key; word_t n; } job_t;
    typedef struct { logic id; word_t res; logic err; } ev_t;
    typedef struct {
        int                  c0;
        int                  c1;
        job_t                j0;
        job_t                j1;
        int                  exp_starts;
        int                  exp_n;
        logic [3:0]          exp_id;
        logic [3:0]          exp_err;
        logic [3:0][W-1:0]   exp_res;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rsa_job_arbiter_if #(.W(W)) bus();
    rsa_job_arbiter #(.W(W), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int viol = 0;
    always @(posedge clk) cyc <= cyc + 1;

    job_t q0[$];
    job_t q1[$];
    ev_t  results[$];
    int   gnt_ids[$];
    int   gnt_cyc[$];
    int   start_cyc[$];
    int   abort_cyc[$];
    int   raise_cyc0 = 0;

    function automatic word_t modexp(word_t m, word_t k, word_t n);
        logic [2*W-1:0] r, b, nn;
        if (n < 2) return '0;
        nn = {{W{1'b0}}, n};
        r = '0;
        r[0] = 1'b1;
        b = {{W{1'b0}}, m} % nn;
        for (int i = 0; i < W; i++) begin
            if (k[i]) r = (r * b) % nn;
            b = (b * b) % nn;
        end
        return r[W-1:0];
    endfunction

    // Engine model: result after a fixed or random latency; hang models an engine that never finishes.
    logic  eng_done_r = 1'b0;
    logic  stray_done = 1'b0;
    word_t eng_c_r = '0;
    word_t eng_pending = '0;
    int    eng_cnt = -1;
    int    eng_lat_fixed = 5;
    bit    eng_hang = 1'b0;
    assign bus.eng_done = eng_done_r | stray_done;
    assign bus.eng_c    = eng_c_r;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_cnt    <= -1;
            eng_done_r <= 1'b0;
        end else begin
            eng_done_r <= 1'b0;
            if (bus.eng_start) begin
                eng_pending <= modexp(bus.eng_msg, bus.eng_key, bus.eng_n);
                eng_cnt <= eng_hang ? -1 : (eng_lat_fixed > 0 ? eng_lat_fixed : int'($urandom_range(1, 8)));
            end else if (bus.eng_abort) begin
                eng_cnt <= -1;
            end else if (eng_cnt == 1) begin
                eng_done_r <= 1'b1;
                eng_c_r    <= eng_pending;
                eng_cnt    <= -1;
            end else if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.gnt0 && bus.gnt1) viol++;
        if (bus.res_valid && bus.eng_start) viol++;
        if (bus.gnt0) begin gnt_ids.push_back(0); gnt_cyc.push_back(cyc); end
        if (bus.gnt1) begin gnt_ids.push_back(1); gnt_cyc.push_back(cyc); end
        if (bus.eng_start) start_cyc.push_back(cyc);
        if (bus.eng_abort) abort_cyc.push_back(cyc);
        if (bus.res_valid) results.push_back('{bus.res_id, bus.res, bus.res_err});
    end

    // Client model: queue head is the live request; a gnt consumes it.
    initial begin
        logic g0, g1, prev0;
        bus.req0 = 1'b0; bus.msg0 = '0; bus.key0 = '0; bus.n0 = '0;
        bus.req1 = 1'b0; bus.msg1 = '0; bus.key1 = '0; bus.n1 = '0;
        forever begin
            @(negedge clk);
            g0 = bus.gnt0;
            g1 = bus.gnt1;
            @(posedge clk);
            #1;
            if (g0 && q0.size() > 0) void'(q0.pop_front());
            if (g1 && q1.size() > 0) void'(q1.pop_front());
            prev0 = bus.req0;
            if (q0.size() > 0) begin
                bus.req0 = 1'b1; bus.msg0 = q0[0].msg; bus.key0 = q0[0].key; bus.n0 = q0[0].n;
            end else bus.req0 = 1'b0;
            if (q1.size() > 0) begin
                bus.req1 = 1'b1; bus.msg1 = q1[0].msg; bus.key1 = q1[0].key; bus.n1 = q1[0].n;
            end else bus.req1 = 1'b0;
            if (!prev0 && bus.req0) raise_cyc0 = cyc;
        end
    end

    task automatic checkw(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic any_out();
        return |{bus.gnt0, bus.gnt1, bus.res, bus.res_valid, bus.res_id, bus.res_err, bus.busy,
                 bus.eng_start, bus.eng_msg, bus.eng_key, bus.eng_n, bus.eng_abort};
    endfunction

    task automatic clear_events();
        results.delete(); gnt_ids.delete(); gnt_cyc.delete(); start_cyc.delete(); abort_cyc.delete();
    endtask

    task automatic apply_reset(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        q0.delete(); q1.delete();
        eng_hang = 1'b0;
        stray_done = 1'b0;
        #1 checki({tag, "_reset_outs"}, int'(any_out()), 0);
        repeat (2) @(posedge clk);
        clear_events();
        #1 reset = 1'b1;
    endtask

    task automatic wait_idle(input int n_exp, input string tag);
        int t = 0;
        while ((results.size() < n_exp || q0.size() != 0 || q1.size() != 0 || bus.busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        checki({tag, "_done"}, int'(t < 3000), 1);
    endtask

    function automatic job_t mkjob(input int m, input int k, input int n);
        job_t j;
        j.msg = word_t'(m); j.key = word_t'(k); j.n = word_t'(n);
        return j;
    endfunction

    function automatic vec_t mk(input int c0, input int c1, input job_t j0, input job_t j1,
                                input int st, input int n, input logic [3:0] ids, input logic [3:0] errs,
                                input int r0, input int r1, input int r2, input int r3);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.j0 = j0; v.j1 = j1;
        v.exp_starts = st; v.exp_n = n; v.exp_id = ids; v.exp_err = errs;
        v.exp_res[0] = word_t'(r0); v.exp_res[1] = word_t'(r1);
        v.exp_res[2] = word_t'(r2); v.exp_res[3] = word_t'(r3);
        return v;
    endfunction

    function automatic job_t rand_job();
        job_t j;
        int kind;
        j.msg = '0; j.key = '0; j.n = '0;
        kind = int'($urandom_range(0, 7));
        j.n[63:0] = {$urandom, $urandom};
        j.key[31:0] = $urandom;
        if (kind == 0) begin
            j.n = word_t'($urandom_range(0, 1));
            j.msg = word_t'($urandom_range(0, 3));
        end else if (kind == 1) begin
            j.msg = j.n + word_t'($urandom_range(0, 3));
        end else begin
            if (kind == 2) j.n[127:96] = $urandom;
            j.msg[95:0] = {$urandom, $urandom, $urandom};
            if (j.n > 1) j.msg = j.msg % j.n;
        end
        return j;
    endfunction

    localparam int NV = 8;
    vec_t tbl[NV];

    initial begin
        job_t z, ja, jb;
        int t;
        int bad;
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        job_t z, ja, jb, l0[$], l1[$];
        ev_t exp_q[$];
        int t, bad, c0, c1, i0, i1, nstart;
        logic last, pk;
        z  = mkjob(0, 0, 0);
        ja = mkjob(2, 10, 1000);
        jb = mkjob(3, 4, 100);
        tbl[0] = mk(1, 0, ja, z, 1, 1, 4'b0000, 4'b0000, 24, 0, 0, 0);
        tbl[1] = mk(2, 2, ja, jb, 4, 4, 4'b1010, 4'b0000, 24, 81, 24, 81);
        tbl[2] = mk(0, 1, z, mkjob(5, 3, 1), 0, 1, 4'b0001, 4'b0001, 0, 0, 0, 0);
        tbl[3] = mk(0, 1, z, mkjob(1000, 3, 1000), 0, 1, 4'b0001, 4'b0001, 0, 0, 0, 0);
        tbl[4] = mk(1, 0, mkjob(999, 1, 1000), z, 1, 1, 4'b0000, 4'b0000, 999, 0, 0, 0);
        tbl[5] = mk(1, 0, mkjob(1, 5, 2), z, 1, 1, 4'b0000, 4'b0000, 1, 0, 0, 0);
        tbl[6] = mk(1, 1, mkjob(5, 3, 5), jb, 1, 2, 4'b0010, 4'b0001, 0, 81, 0, 0);
        tbl[7] = mk(1, 0, mkjob(0, 7, 0), z, 0, 1, 4'b0000, 4'b0001, 0, 0, 0, 0);

        for (int v = 0; v < NV; v++) begin
            apply_reset($sformatf("tbl%0d", v));
            eng_lat_fixed = 5;
            for (int r = 0; r < tbl[v].c0; r++) q0.push_back(tbl[v].j0);
            for (int r = 0; r < tbl[v].c1; r++) q1.push_back(tbl[v].j1);
            wait_idle(tbl[v].exp_n, $sformatf("tbl%0d", v));
            checki($sformatf("tbl%0d_nres", v), results.size(), tbl[v].exp_n);
            checki($sformatf("tbl%0d_nstart", v), start_cyc.size(), tbl[v].exp_starts);
            checki($sformatf("tbl%0d_ngnt", v), gnt_ids.size(), tbl[v].exp_n);
            for (int k = 0; k < tbl[v].exp_n && k < results.size() && k < gnt_ids.size(); k++) begin
                checki($sformatf("tbl%0d_gnt%0d", v, k), gnt_ids[k], int'(tbl[v].exp_id[k]));
                checki($sformatf("tbl%0d_id%0d", v, k), int'(results[k].id), int'(tbl[v].exp_id[k]));
                checki($sformatf("tbl%0d_err%0d", v, k), int'(results[k].err), int'(tbl[v].exp_err[k]));
                checkw($sformatf("tbl%0d_res%0d", v, k), results[k].res, tbl[v].exp_res[k]);
            end
        end

        // Grant latency from request rise, with eng_start on the same cycle.
        apply_reset("lat");
        q0.push_back(ja);
        t = 0;
        while (gnt_cyc.size() == 0 && t < 100) begin @(negedge clk); t++; end
        checki("lat_gnt_seen", int'(t < 100), 1);
        if (gnt_cyc.size() > 0 && start_cyc.size() > 0) begin
            checki("lat_gnt_cycles", gnt_cyc[0] - raise_cyc0, 2);
            checki("lat_start_with_gnt", start_cyc[0], gnt_cyc[0]);
        end
        wait_idle(1, "lat");

        // Reset three cycles into WAIT: outputs clear at once, the job never reports.
        apply_reset("rstw");
        eng_lat_fixed = 20;
        q0.push_back(ja);
        t = 0;
        while (start_cyc.size() == 0 && t < 100) begin @(negedge clk); t++; end
        checki("rstw_start_seen", int'(t < 100), 1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1 checki("rstw_async_clear", int'(any_out()), 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(negedge clk);
        checki("rstw_no_result", results.size(), 0);
        eng_lat_fixed = 5;
        q1.push_back(jb);
        wait_idle(1, "rstw_next");
        checki("rstw_next_n", results.size(), 1);
        if (results.size() > 0) begin
            checkw("rstw_next_res", results[0].res, word_t'(81));
            checki("rstw_next_id", int'(results[0].id), 1);
        end

        // Stray done while IDLE.
        apply_reset("stray");
        @(posedge clk);
        #1 stray_done = 1'b1;
        @(posedge clk);
        #1 stray_done = 1'b0;
        bad = 0;
        repeat (6) begin @(negedge clk); if (bus.busy) bad++; end
        checki("stray_busy", bad, 0);
        checki("stray_events", results.size() + gnt_ids.size() + start_cyc.size(), 0);

`ifdef RSA_ARB_TIMEOUT_EN
        apply_reset("tmo");
        eng_hang = 1'b1;
        q0.push_back(ja);
        t = 0;
        while (abort_cyc.size() == 0 && t < 200) begin @(negedge clk); t++; end
        checki("tmo_abort_seen", int'(t < 200), 1);
        if (abort_cyc.size() > 0 && start_cyc.size() > 0)
            checki("tmo_abort_cycles", abort_cyc[0] - start_cyc[0], 16);
        eng_hang = 1'b0;
        q1.push_back(jb);
        wait_idle(2, "tmo");
        checki("tmo_nres", results.size(), 2);
        if (results.size() == 2) begin
            checki("tmo_err", int'(results[0].err), 1);
            checkw("tmo_res", results[0].res, '0);
            checkw("tmo_next_res", results[1].res, word_t'(81));
            checki("tmo_next_err", int'(results[1].err), 0);
        end
`endif

        // Randomized rounds against a round-robin order model.
        for (int rnd = 0; rnd < 6; rnd++) begin
            apply_reset($sformatf("rnd%0d", rnd));
            eng_lat_fixed = 0;
            l0.delete(); l1.delete(); exp_q.delete();
            c0 = int'($urandom_range(0, 4));
            c1 = int'($urandom_range(0, 4));
            for (int i = 0; i < c0; i++) l0.push_back(rand_job());
            for (int i = 0; i < c1; i++) l1.push_back(rand_job());
            last = 1'b1; i0 = 0; i1 = 0; nstart = 0;
            while (i0 < c0 || i1 < c1) begin
                job_t j;
                pk = (i0 < c0 && i1 < c1) ? ~last : (i1 < c1);
                j = pk ? l1[i1] : l0[i0];
                if (pk) i1++; else i0++;
                last = pk;
                if (j.n < 2 || j.msg >= j.n) exp_q.push_back('{pk, '0, 1'b1});
                else begin
                    exp_q.push_back('{pk, modexp(j.msg, j.key, j.n), 1'b0});
                    nstart++;
                end
            end
            foreach (l0[i]) q0.push_back(l0[i]);
            foreach (l1[i]) q1.push_back(l1[i]);
            wait_idle(exp_q.size(), $sformatf("rnd%0d", rnd));
            checki($sformatf("rnd%0d_nres", rnd), results.size(), exp_q.size());
            checki($sformatf("rnd%0d_nstart", rnd), start_cyc.size(), nstart);
            for (int k = 0; k < exp_q.size() && k < results.size() && k < gnt_ids.size(); k++) begin
                checki($sformatf("rnd%0d_gnt%0d", rnd, k), gnt_ids[k], int'(exp_q[k].id));
                checki($sformatf("rnd%0d_id%0d", rnd, k), int'(results[k].id), int'(exp_q[k].id));
                checki($sformatf("rnd%0d_err%0d", rnd, k), int'(results[k].err), int'(exp_q[k].err));
                checkw($sformatf("rnd%0d_res%0d", rnd, k), results[k].res, exp_q[k].res);
            end
        end

        checki("invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
